// File: rtl/fifo_pkg.sv
// fifo_pkg: default sizing constants and the level/pointer width helper shared by the FIFO files
package fifo_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 16;
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: simple dual-port RAM, one write and one registered read port on clk, no reset
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: synchronous FIFO with registered status and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output; default is registered-pop output.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = 14,
  parameter int AE_THRESH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          din,
  input  logic                      wr_en,
  input  logic                      rd_en,
  output logic [WIDTH-1:0]          dout,
  output logic                      dout_valid,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [lvl_w(DEPTH)-1:0]   level,
  output logic                      overflow,
  output logic                      underflow,
  input  logic                      clr_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = lvl_w(DEPTH);
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of two >= 4");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("sync_fifo: AF_THRESH must be in 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo: AE_THRESH must be in 0..DEPTH-1");
  end
  logic [PW-1:0]    r_wr_ptr, r_rd_ptr, r_level;
  logic             r_full, r_empty, r_af, r_ae, r_ovf, r_udf;
  logic             w_wr_ok, w_rd_ok, w_re;
  logic [PW-1:0]    w_level_nxt, w_rd_ptr_nxt;
  logic [AW-1:0]    w_raddr;
  logic [WIDTH-1:0] w_rdata;
  assign w_wr_ok      = wr_en & ~r_full;
  assign w_rd_ok      = rd_en & ~r_empty;
  assign w_level_nxt  = r_level + PW'(w_wr_ok) - PW'(w_rd_ok);
  assign w_rd_ptr_nxt = r_rd_ptr + PW'(w_rd_ok);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_af     <= 1'b0;
      r_ae     <= 1'b1;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PW'(w_wr_ok);
      r_rd_ptr <= w_rd_ptr_nxt;
      r_level  <= w_level_nxt;
      r_full   <= w_level_nxt == PW'(DEPTH);
      r_empty  <= w_level_nxt == '0;
      r_af     <= w_level_nxt >= PW'(AF_THRESH);
      r_ae     <= w_level_nxt <= PW'(AE_THRESH);
      r_ovf    <= (wr_en & r_full) | (r_ovf & ~clr_err);
      r_udf    <= (rd_en & r_empty) | (r_udf & ~clr_err);
    end
  end
  assign level        = r_level;
  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_af;
  assign almost_empty = r_ae;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;
`ifdef SYNC_FIFO_FWFT_EN
  // RAM always prefetches the next head; a write landing on that slot is bypassed
  logic             r_byp;
  logic [WIDTH-1:0] r_byp_data;
  assign w_re    = 1'b1;
  assign w_raddr = w_rd_ptr_nxt[AW-1:0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byp      <= 1'b0;
      r_byp_data <= '0;
    end else begin
      r_byp      <= w_wr_ok && (r_wr_ptr[AW-1:0] == w_raddr);
      r_byp_data <= din;
    end
  end
  assign dout       = r_empty ? '0 : r_byp ? r_byp_data : w_rdata;
  assign dout_valid = ~r_empty;
`else
  // RAM output holds between pops; r_rd_seen masks it to zero until the first pop after reset
  logic r_rd_seen, r_dvalid;
  assign w_re    = w_rd_ok;
  assign w_raddr = r_rd_ptr[AW-1:0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_seen <= 1'b0;
      r_dvalid  <= 1'b0;
    end else begin
      r_rd_seen <= r_rd_seen | w_rd_ok;
      r_dvalid  <= w_rd_ok;
    end
  end
  assign dout       = r_rd_seen ? w_rdata : '0;
  assign dout_valid = r_dvalid;
`endif
  fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk     (clk),
    .i_we    (w_wr_ok),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (din),
    .i_re    (w_re),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: scoreboard bench for sync_fifo; works with or without SYNC_FIFO_FWFT_EN
module tb_sync_fifo;
  logic        clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic [31:0] din = '0, dout;
  logic        dout_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0]  level;
  int          n_chk = 0, n_err = 0, m_level = 0;
  logic [31:0] exp_q[$], mq[$];
  logic        m_ovf = 1'b0, m_udf = 1'b0;
  logic [31:0] m_last = '0;
  always #5 clk = ~clk;
  sync_fifo #(.WIDTH(32), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .level(level),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  // monitor: every word the DUT presents is matched against the scoreboard head
  always @(negedge clk) begin
`ifdef SYNC_FIFO_FWFT_EN
    if (rst_n && rd_en && dout_valid) begin
`else
    if (rst_n && dout_valid) begin
`endif
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL dout: got unexpected word %0h, expected none", dout);
      end else chk("dout", dout, exp_q.pop_front());
    end
  end
  task automatic op(input logic wr, input logic rd, input logic clr, input logic [31:0] d);
    logic wok, rok;
    wr_en = wr; rd_en = rd; clr_err = clr; din = d;
    wok = wr && m_level < 16;
    rok = rd && m_level > 0;
    m_ovf = (wr && m_level == 16) || (m_ovf && !clr);
    m_udf = (rd && m_level == 0) || (m_udf && !clr);
    if (rok) m_last = mq.pop_front();
    if (wok) begin
      mq.push_back(d);
      exp_q.push_back(d);
    end
    m_level += int'(wok) - int'(rok);
    @(posedge clk); #1;
    chk("level", 32'(level), 32'(m_level));
    chk("full", 32'(full), 32'(m_level == 16));
    chk("empty", 32'(empty), 32'(m_level == 0));
    chk("almost_full", 32'(almost_full), 32'(m_level >= 14));
    chk("almost_empty", 32'(almost_empty), 32'(m_level <= 2));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_udf));
`ifdef SYNC_FIFO_FWFT_EN
    chk("dout_valid", 32'(dout_valid), 32'(m_level != 0));
`else
    chk("dout_valid", 32'(dout_valid), 32'(rok));
`endif
  endtask
  task automatic do_reset();
    @(negedge clk); #2;
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    #1;
    chk("rst_level", 32'(level), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_almost_empty", 32'(almost_empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_almost_full", 32'(almost_full), 0);
    chk("rst_dout", dout, 0);
    chk("rst_dout_valid", 32'(dout_valid), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_underflow", 32'(underflow), 0);
    exp_q.delete(); mq.delete();
    m_level = 0; m_ovf = 1'b0; m_udf = 1'b0; m_last = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    do_reset();
    for (int i = 0; i < 8; i++) op(1, 0, 0, 32'(i));
    for (int i = 0; i < 8; i++) op(0, 1, 0, 0);
    op(0, 0, 0, 0);
    for (int i = 0; i < 17; i++) op(1, 0, 0, 32'(100 + i));
    chk("full_at_16", 32'(full), 1);
    op(0, 0, 1, 0);
    chk("ovf_cleared_level", 32'(level), 16);
    op(1, 1, 0, 32'h999);
    chk("full_wr_rd_level", 32'(level), 15);
    op(0, 0, 1, 0);
    for (int i = 0; i < 15; i++) op(0, 1, 0, 0);
    op(0, 0, 0, 0);
    op(0, 1, 0, 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("dout_hold_underflow", dout, 32'd115);
`endif
    op(0, 0, 1, 0);
    op(1, 1, 0, 32'h200);
    chk("empty_wr_rd_level", 32'(level), 1);
    for (int i = 1; i < 5; i++) op(1, 0, 0, 32'(32'h200 + i));
    op(1, 1, 0, 32'h205);
    chk("mid_wr_rd_level", 32'(level), 5);
    op(0, 0, 1, 0);
    for (int i = 0; i < 5; i++) op(0, 1, 0, 0);
    op(0, 0, 0, 0);
    for (int i = 0; i < 13; i++) op(1, 0, 0, 32'(32'h300 + i));
    chk("af_at_13", 32'(almost_full), 0);
    op(1, 0, 0, 32'h30d);
    chk("af_at_14", 32'(almost_full), 1);
    op(1, 0, 0, 32'h30e);
    op(1, 0, 0, 32'h30f);
    for (int i = 0; i < 13; i++) op(0, 1, 0, 0);
    chk("ae_at_3", 32'(almost_empty), 0);
    op(0, 1, 0, 0);
    chk("ae_at_2", 32'(almost_empty), 1);
    op(0, 1, 0, 0);
    op(0, 1, 0, 0);
    op(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) op(1, 0, 0, 32'(32'h1000 + i));
    for (int i = 0; i < 40; i++) op(1, 1, 0, 32'(32'h1004 + i));
    for (int i = 0; i < 4; i++) op(0, 1, 0, 0);
    op(0, 0, 0, 0);
    for (int i = 0; i < 9; i++) op(1, 0, 0, 32'(32'h500 + i));
    chk("level_before_reset", 32'(level), 9);
    do_reset();
    op(1, 0, 0, 32'hA5A5A5A5);
    op(0, 1, 0, 0);
    op(0, 0, 0, 0);
    chk("empty_after_a5", 32'(empty), 1);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, entries; power of two >= 4, else elaboration error.
REQ-003 SHALL have parameter AF_THRESH, default 14, almost_full level; range 1..DEPTH, else elaboration error.
REQ-004 SHALL have parameter AE_THRESH, default 2, almost_empty level; range 0..DEPTH-1, else elaboration error.
REQ-005 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports din (in, WIDTH, write data) and wr_en (in, 1, write request).
REQ-008 SHALL have port rd_en  in  1  read/pop request.
REQ-009 SHALL have ports dout (out, WIDTH, read data) and dout_valid (out, 1, dout holds a popped/head word).
REQ-010 SHALL have ports full, empty, almost_full, almost_empty  out  1 each  status flags.
REQ-011 SHALL have port level  out  $clog2(DEPTH)+1  current occupancy 0..DEPTH.
REQ-012 SHALL have ports overflow, underflow (out, 1, sticky error flags) and clr_err (in, 1, clears both).

Function
REQ-013 SHALL accept a write iff wr_en && !full; full blocks writes even when rd_en is asserted in the same cycle.
REQ-014 SHALL accept a read iff rd_en && !empty.
REQ-015 SHALL update level, full, empty, almost_full, almost_empty on the clock edge of the accepted operation; net level: +1 write only, -1 read only, 0 both.
REQ-016 SHALL drive full = (level == DEPTH), empty = (level == 0), almost_full = (level >= AF_THRESH), almost_empty = (level <= AE_THRESH), all registered.
REQ-017 SHALL use read/write pointers of $clog2(DEPTH)+1 bits that wrap modulo 2*DEPTH; the address is the low $clog2(DEPTH) bits.
REQ-018 SHALL, at level DEPTH with wr_en && rd_en, pop one word, reject the write, set overflow, and go to level DEPTH-1.
REQ-019 SHALL, at level 0 with wr_en && rd_en, accept the write, reject the read, set underflow, and go to level 1.
REQ-020 SHALL set overflow on wr_en && full and underflow on rd_en && empty; both stay set until clr_err; if set and clear coincide, set wins.
REQ-021 SHALL leave memory, pointers and dout unchanged by rejected operations.
REQ-022 SHALL preserve strict FIFO order across any number of pointer wraps.

Reset
REQ-023 SHALL, while rst_n is low, force asynchronously: level=0, empty=1, almost_empty=1, full=0, almost_full=0, dout=0, dout_valid=0, overflow=0, underflow=0, pointers=0.
REQ-024 SHALL discard all stored words when reset is asserted mid-operation; memory contents need no reset.
REQ-025 SHALL accept a write on the first rising clk edge after rst_n deasserts.

Configuration
REQ-026 SHALL support macro SYNC_FIFO_FWFT_EN.
REQ-027 SHALL, with SYNC_FIFO_FWFT_EN defined, run first-word-fall-through: dout = head word and dout_valid = !empty; rd_en pops the head; a write into an empty FIFO shows on dout in the cycle after the write.
REQ-028 SHALL, without SYNC_FIFO_FWFT_EN, run standard mode: dout is registered with the popped word and dout_valid is high for exactly one cycle, the cycle after an accepted read; otherwise dout holds its value.

Structure
REQ-029 SHALL place the shared package fifo_pkg holding the default WIDTH/DEPTH constants and the level/pointer width helper function.
REQ-030 SHALL instantiate one sub-module fifo_mem: simple dual-port RAM, one write and one read port, both on clk, no reset.

Verification (WIDTH=32, DEPTH=16, AF_THRESH=14, AE_THRESH=2; both macro settings)
REQ-031 SHALL cover: reset, write 0..7, read 8 -> dout 0..7 in order, then empty=1, level=0, no error flags.
REQ-032 SHALL cover: 17 consecutive writes -> full=1 at level 16, 17th rejected, overflow=1; clr_err pulse -> overflow=0, level still 16.
REQ-033 SHALL cover: rd_en at level 0 -> underflow=1, dout unchanged, level 0; wr_en+rd_en at level 16 -> level 15, overflow=1; wr_en+rd_en at level 5 -> level 5.
REQ-034 SHALL cover: thresholds -> almost_full=1 at level 14 but 0 at 13; almost_empty=1 at level 2 but 0 at 3.
REQ-035 SHALL cover: 40 words streamed with simultaneous wr/rd (3 pointer wraps) -> all values returned in order, level never exceeds 16.
REQ-036 SHALL cover: rst_n low at level 9 -> all outputs at reset values; after release, write 0xA5A5A5A5 and read -> 0xA5A5A5A5, then empty=1.
